// File: rtl/prog_inst_mem_if.sv
// Fetch/load bundle for prog_inst_mem: load port, req/ready fetch issue, stall,
// and the valid-qualified instruction/fault return.
interface prog_inst_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_err;
    logic              req;
    logic [ADDR_W-1:0] req_addr;
    logic              ready;
    logic              stall;
    logic              valid;
    logic [DATA_W-1:0] inst;
    logic              fault;

    modport master (
        output load_en, load_addr, load_data, req, req_addr, stall,
        input  load_err, ready, valid, inst, fault
    );

    modport slave (
        input  load_en, load_addr, load_data, req, req_addr, stall,
        output load_err, ready, valid, inst, fault
    );
endinterface

// File: rtl/prog_inst_mem.sv
// Loadable instruction memory with a LATENCY-stage fetch pipeline (valid LATENCY cycles after accept).
// ready drops during load/stall/reset; stall freezes every stage and the outputs, non-accepted requests are dropped.
module prog_inst_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    prog_inst_mem_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] flt_q, flt_d;
    logic [DATA_W-1:0]  dat_q [LATENCY];
    logic [DATA_W-1:0]  dat_d [LATENCY];
    logic               load_err_q, load_err_d;

    logic               wr_in_range;
    logic               rd_in_range;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               ready;
    logic               accept;

    assign wr_in_range = ({1'b0, bus.load_addr} < DEPTH_C);
    assign rd_in_range = ({1'b0, bus.req_addr} < DEPTH_C);
    assign wr_idx      = bus.load_addr[IDX_W-1:0];
    assign rd_idx      = bus.req_addr[IDX_W-1:0];

    assign ready  = ~bus.load_en & ~bus.stall & ~rst;
    assign accept = bus.req & ready;

    assign load_err_d = bus.load_en & ~wr_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.load_en && wr_in_range) begin
            mem_q[wr_idx] <= bus.load_data;
        end
    end

    // Data/fault only move with a valid entry, so the output stage keeps the
    // last delivered instruction while valid is low.
    always_comb begin
        vld_d = vld_q;
        flt_d = flt_q;
        dat_d = dat_q;
        if (!bus.stall) begin
            vld_d[0] = accept;
            if (accept) begin
                dat_d[0] = rd_in_range ? mem_q[rd_idx] : '0;
                flt_d[0] = ~rd_in_range;
            end
            for (int s = 1; s < LATENCY; s++) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    dat_d[s] = dat_q[s-1];
                    flt_d[s] = flt_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            flt_q      <= '0;
            load_err_q <= 1'b0;
            for (int s = 0; s < LATENCY; s++) begin
                dat_q[s] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            flt_q      <= flt_d;
            dat_q      <= dat_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.ready    = ready;
    assign bus.valid    = vld_q[LATENCY-1];
    assign bus.inst     = dat_q[LATENCY-1];
    assign bus.fault    = flt_q[LATENCY-1];
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_prog_inst_mem.sv
// Scoreboarded bench: three prog_inst_mem instances (LATENCY 1..3) share one stimulus stream.
`timescale 1ns/1ps
module tb_prog_inst_mem;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 64;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] dat;
        logic        flt;
        int          adv;
    } sb_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          load_en   = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          req       = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic          stall     = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int adv_cnt = 0;
    int last_acc_cyc = 0;

    logic [31:0] model_mem [DEPTH];
    sb_t         sbq [3][$];

    always #5 clk = ~clk;

    // Edges that move the pipeline: not in reset and not stalled.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && !stall) adv_cnt <= adv_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic score(input int lat, input sb_t e, input logic [31:0] inst, input logic flt);
        check($sformatf("inst_l%0d_a%0d", lat, e.addr), inst, e.dat);
        check($sformatf("fault_l%0d_a%0d", lat, e.addr), 32'(flt), 32'(e.flt));
        check($sformatf("time_l%0d_a%0d", lat, e.addr), 32'(adv_cnt), 32'(e.adv + lat - 1));
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = g + 1;
        prog_inst_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

        assign bus.load_en   = load_en;
        assign bus.load_addr = load_addr;
        assign bus.load_data = load_data;
        assign bus.req       = req;
        assign bus.req_addr  = req_addr;
        assign bus.stall     = stall;

        prog_inst_mem #(
            .DATA_W (DW),
            .ADDR_W (AW),
            .DEPTH  (DEPTH),
            .LATENCY(LAT)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );

        logic fresh = 1'b1;

        always @(negedge clk) begin
            if (rst) begin
                check($sformatf("rst_valid_l%0d", LAT), 32'(bus.valid), 32'd0);
                sbq[g].delete();
            end else if (bus.valid && fresh) begin
                if (sbq[g].size() == 0)
                    check($sformatf("unexpected_valid_l%0d", LAT), 32'(bus.valid), 32'd0);
                else
                    score(LAT, sbq[g].pop_front(), bus.inst, bus.fault);
            end
            fresh <= ~stall;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        if (a < DEPTH) model_mem[a] = d;
        load_en = 1'b0;
    endtask

    // Leaves req high on return so callers can chain back-to-back fetches.
    task automatic fetch(input logic [15:0] a);
        logic r;
        bit   done;
        sb_t  e;
        done     = 0;
        req      = 1'b1;
        req_addr = a;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            r = !load_en && !stall && !rst;
            check($sformatf("ready_a%0d", a), 32'(g_dut[0].bus.ready), 32'(r));
            step();
            if (r) done = 1;
        end
        check($sformatf("accept_timeout_a%0d", a), 32'(done), 32'd1);
        if (done) begin
            e.addr = a;
            e.flt  = (a >= DEPTH);
            e.dat  = e.flt ? 32'h0 : model_mem[a];
            e.adv  = adv_cnt;
            for (int i = 0; i < 3; i++) sbq[i].push_back(e);
            last_acc_cyc = cyc;
        end
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_v0"}, 32'(g_dut[0].bus.valid), 32'd0);
        check({tag, "_v1"}, 32'(g_dut[1].bus.valid), 32'd0);
        check({tag, "_v2"}, 32'(g_dut[2].bus.valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drop_cyc;
        logic [31:0] held;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        #2 rst = 1'b1;

        // Reset state
        @(negedge clk);
        check_all_idle("rst_state");
        check("rst_inst",  g_dut[0].bus.inst, 32'h0);
        check("rst_fault", 32'(g_dut[1].bus.fault), 32'd0);
        check("rst_lerr",  32'(g_dut[2].bus.load_err), 32'd0);
        check("rst_ready", 32'(g_dut[0].bus.ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // 1: back-to-back fetches of cleared memory
        for (int a = 0; a < 4; a++) fetch(16'(a));
        req = 1'b0;
        repeat (4) step();

        // 2: load then fetch
        do_load(16'd5, 32'h4820_4001);
        fetch(16'd5);
        req = 1'b0;
        repeat (4) step();

        // 3: out-of-range fetches, top in-range word, rejected load
        do_load(16'd63, 32'hA5A5_0063);
        @(negedge clk);
        check("lerr_good_load", 32'(g_dut[0].bus.load_err), 32'd0);
        step();
        fetch(16'd64);
        fetch(16'hFFFF);
        fetch(16'd63);
        req = 1'b0;
        repeat (4) step();
        do_load(16'd70, 32'hDEAD_BEEF);
        @(negedge clk);
        check("lerr_pulse_l1", 32'(g_dut[0].bus.load_err), 32'd1);
        check("lerr_pulse_l3", 32'(g_dut[2].bus.load_err), 32'd1);
        step();
        @(negedge clk);
        check("lerr_drop", 32'(g_dut[0].bus.load_err), 32'd0);
        step();
        fetch(16'd6);
        req = 1'b0;
        repeat (4) step();

        // 4: two-cycle stall while LATENCY=2 instance presents an instruction
        do_load(16'd10, 32'h1111_0010);
        do_load(16'd11, 32'h2222_0011);
        do_load(16'd12, 32'h3333_0012);
        fetch(16'd10);
        fetch(16'd11);
        req   = 1'b0;
        stall = 1'b1;
        @(negedge clk);
        check("stall_v_c1", 32'(g_dut[1].bus.valid), 32'd1);
        held = g_dut[1].bus.inst;
        check("stall_inst_c1", held, 32'h1111_0010);
        check("stall_ready_c1", 32'(g_dut[1].bus.ready), 32'd0);
        step();
        @(negedge clk);
        check("stall_v_c2", 32'(g_dut[1].bus.valid), 32'd1);
        check("stall_inst_c2", g_dut[1].bus.inst, 32'h1111_0010);
        check("stall_ready_c2", 32'(g_dut[1].bus.ready), 32'd0);
        step();
        stall = 1'b0;
        @(negedge clk);
        check("stall_v_c3", 32'(g_dut[1].bus.valid), 32'd1);
        check("stall_inst_c3", g_dut[1].bus.inst, 32'h1111_0010);
        step();
        fetch(16'd12);
        fetch(16'd10);
        req = 1'b0;
        repeat (5) step();

        // 5: request held across a two-word load
        req       = 1'b1;
        req_addr  = 16'd20;
        load_en   = 1'b1;
        load_addr = 16'd20;
        load_data = 32'hCAFE_0020;
        @(negedge clk);
        check("load_ready_c1", 32'(g_dut[2].bus.ready), 32'd0);
        step();
        model_mem[20] = 32'hCAFE_0020;
        load_addr = 16'd21;
        load_data = 32'hCAFE_0021;
        @(negedge clk);
        check("load_ready_c2", 32'(g_dut[0].bus.ready), 32'd0);
        step();
        model_mem[21] = 32'hCAFE_0021;
        load_en  = 1'b0;
        drop_cyc = cyc;
        fetch(16'd20);
        check("load_accept_cyc", 32'(last_acc_cyc), 32'(drop_cyc + 1));
        req = 1'b0;
        repeat (5) step();

        // 6: reset with fetches in flight
        do_load(16'd30, 32'h7777_0030);
        fetch(16'd30);
        fetch(16'd31);
        req = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        #1;
        check_all_idle("rst_mid");
        check("rst_mid_inst_l3", g_dut[2].bus.inst, 32'h0);
        step();
        step();
        rst = 1'b0;
        repeat (6) step();
        fetch(16'd30);
        req = 1'b0;
        repeat (6) step();

        for (int i = 0; i < 3; i++)
            check($sformatf("drain_l%0d", i + 1), 32'(sbq[i].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_inst_mem.md
Name: prog_inst_mem

Overview:
- Parametrised, loadable instruction memory for the NanoQuarter demo and test harnesses.
- Next generation of the hard-coded fake instruction source: generalised width and depth, and programmable at runtime through a load port.
- Has a req/valid fetch handshake with configurable read latency, a stall input, and range-fault reporting.
- Sits between the fetch stage and either the demo loader or a testbench.

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 16, address width of the load and fetch ports.
- DEPTH, 64, number of instruction words. Legal range 2..2^ADDR_W.
- LATENCY, 1, fetch pipeline depth in cycles. Legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  write load_data to load_addr this cycle.
- load_addr  in  ADDR_W  load word address.
- load_data  in  DATA_W  load word.
- load_err  out  1  one-cycle pulse: load_addr >= DEPTH.
- req  in  1  fetch request.
- req_addr  in  ADDR_W  fetch word address.
- ready  out  1  fetch can be accepted this cycle.
- stall  in  1  freeze the fetch pipeline and outputs.
- valid  out  1  inst/fault are valid this cycle.
- inst  out  DATA_W  fetched instruction.
- fault  out  1  qualified by valid: the fetch address was out of range.

Behaviour:
- Reset (async, immediate):
  - All DEPTH words cleared to 0 (NOP).
  - Pipeline stage valids cleared.
  - valid=0, inst=0, fault=0, load_err=0.
  - Any in-flight fetch is discarded, with no valid pulse after reset releases.
- ready (combinational) = ~load_en & ~stall & ~rst.
- A fetch is accepted on a rising edge when req & ready.
  - Requests while ready=0 are dropped, not queued. The requester holds req until accepted.
- Load:
  - On a rising edge with load_en=1 and load_addr < DEPTH, mem[load_addr] <= load_data.
  - If load_addr >= DEPTH: memory is unchanged and load_err=1 for the next cycle only.
  - Load is never blocked by stall.
- Fetch pipeline: LATENCY stages, each holding {valid, addr-in-range, data}.
  - The memory read occurs at stage 0, on the acceptance edge.
  - An accepted fetch at edge k produces valid=1 in the cycle after edge k+LATENCY-1, provided no stall cycles intervene.
  - Each stall cycle adds exactly one cycle of delay.
- Throughput: one fetch per cycle. Back-to-back requests give back-to-back valids in order.
- Output rule: valid is high for exactly one cycle per accepted fetch, unless stalled.
- Stall=1:
  - All stages hold.
  - valid, inst and fault hold their current values, so a presented instruction stays presented.
  - No new acceptance.
- Out of range: req_addr >= DEPTH is accepted normally and returns inst=0, fault=1 with valid.
- Read/write ordering:
  - A load and an acceptance cannot coincide, because ready=0 during load.
  - A fetch accepted the cycle after a load to the same address returns the new data.
  - Fetches already in the pipeline keep their old data.
- When valid=0, inst and fault keep their last values. Only valid qualifies them.
- Width rule: address comparisons are unsigned at ADDR_W bits. No wrap-around: addresses at or above DEPTH always fault.

Test Plan:
1. Reset, then fetch addr 0..3 back-to-back at LATENCY=1:
   - 4 consecutive valids with inst=0, fault=0.
   - First valid appears one cycle after the first acceptance.
2. Load mem[5]=32'h4820_4001, then fetch 5 at LATENCY=3:
   - inst=32'h4820_4001.
   - valid exactly 3 cycles after acceptance.
3. Fetch addr 64 with DEPTH=64:
   - valid=1, fault=1, inst=0.
   - Load to addr 70 -> load_err pulse for 1 cycle, memory unchanged.
4. Stall for 2 cycles while valid=1 at LATENCY=2:
   - inst and valid held for 2 extra cycles.
   - ready=0 throughout.
   - Subsequent fetches still in order with none lost.
5. req held with load_en=1:
   - ready=0, no acceptance.
   - Request accepted on the first cycle after load_en drops, and returns the newly loaded word.
6. Assert rst mid-pipeline with two fetches in flight:
   - valid=0 immediately.
   - No valid after release.
   - Re-fetch of a previously loaded address returns 0.
